// File: rtl/mac_sched.sv
// Two-requester scheduler for a shared radix-4 MAC: round-robin grant,
// clear/run/capture sequencing and a held response per transaction.
//
// state | meaning
// IDLE  | offer grant to one pending requester
// CLEAR | pulse MAC accumulator clear for one cycle
// RUN   | ITER MAC enable cycles, counter 0..ITER-1
// CAPT  | register MAC accumulator into result
// RESP  | present result to owner until it accepts
module mac_sched #(
    parameter int W    = 256,
    parameter int ITER = 128
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_b,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [2*W-1:0] rsp_data,
    output logic [W-1:0]   mac_a,
    output logic [W-1:0]   mac_b,
    output logic           mac_en,
    output logic           mac_clr_n,
    input  logic [2*W-1:0] mac_out,
    output logic           busy
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        CAPT,
        RESP
    } state_t;

    state_t           state;
    logic             ptr;
    logic             owner;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic [2*W-1:0]   result;
    logic             mac_en_r;
    logic             clr_r;
    logic [1:0]       rsp_valid_r;
    logic             busy_r;

    logic             grant_id;
    logic             accept;
    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        grant_id = ptr;
        if (req_valid == 2'b01) begin
            grant_id = 1'b0;
        end else if (req_valid == 2'b10) begin
            grant_id = 1'b1;
        end
    end

    assign req_ready = (rst_n && state == IDLE && req_valid != 2'b00)
                       ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign sel_a     = grant_id ? req_a[W +: W] : req_a[0 +: W];
    assign sel_b     = grant_id ? req_b[W +: W] : req_b[0 +: W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            owner       <= 1'b0;
            cnt         <= '0;
            op_a        <= '0;
            op_b        <= '0;
            result      <= '0;
            mac_en_r    <= 1'b0;
            clr_r       <= 1'b0;
            rsp_valid_r <= 2'b00;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        owner  <= grant_id;
                        ptr    <= ~grant_id;
                        clr_r  <= 1'b1;
                        busy_r <= 1'b1;
                        state  <= CLEAR;
                    end
                end
                CLEAR: begin
                    clr_r    <= 1'b0;
                    cnt      <= '0;
                    mac_en_r <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    if (cnt == CNT_LAST) begin
                        mac_en_r <= 1'b0;
                        state    <= CAPT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CAPT: begin
                    result      <= mac_out;
                    rsp_valid_r <= owner ? 2'b10 : 2'b01;
                    state       <= RESP;
                end
                RESP: begin
                    // Only the owner's accept closes the transaction.
                    if (rsp_ready[owner]) begin
                        rsp_valid_r <= 2'b00;
                        busy_r      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    mac_en_r    <= 1'b0;
                    clr_r       <= 1'b0;
                    rsp_valid_r <= 2'b00;
                    busy_r      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign mac_a     = op_a;
    assign mac_b     = op_b;
    assign mac_en    = mac_en_r;
    assign mac_clr_n = rst_n & ~clr_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = result;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mac_sched.sv
// Scoreboarded bench for mac_sched with a behavioural radix-4 MAC and a
// round-robin grant model; randomized operands and response back-pressure.
`timescale 1ns/1ps
module tb_mac_sched;
    localparam int W    = 256;
    localparam int ITER = 128;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           vld0 = 1'b0, vld1 = 1'b0;
    logic [W-1:0]   a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic [1:0]     req_valid, req_ready, rsp_valid;
    logic [1:0]     rsp_ready = 2'b00;
    logic [2*W-1:0] req_a, req_b, rsp_data, mac_out;
    logic [W-1:0]   mac_a, mac_b;
    logic           mac_en, mac_clr_n, busy;

    assign req_valid = {vld1, vld0};
    assign req_a     = {a1, a0};
    assign req_b     = {b1, b0};

    mac_sched #(.W(W), .ITER(ITER)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en), .mac_clr_n(mac_clr_n),
        .mac_out(mac_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Radix-4 MAC: each enable adds A times the next 2-bit digit of B.
    logic [2*W-1:0] acc = '0;
    int             step = 0;
    always @(posedge clk) begin
        if (!mac_clr_n) begin
            acc  <= '0;
            step <= 0;
        end else if (mac_en) begin
            if (step < W/2)
                acc <= acc + (({{W{1'b0}}, mac_a} * {{(2*W-2){1'b0}}, mac_b[2*step +: 2]}) << (2*step));
            step <= step + 1;
        end
    end
    assign mac_out = acc;

    typedef struct {
        logic           owner;
        logic [2*W-1:0] data;
        int             t_acc;
    } exp_t;
    exp_t sb[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit             m_busy = 0, m_ptr = 0;
    int             en_cnt = 0, clr_cnt = 0;
    logic [1:0]     prev_rv = 2'b00;
    logic [2*W-1:0] prev_data = '0;
    logic [1:0]     exp_rdy;
    logic           g;
    logic [W-1:0]   ea, eb;
    exp_t           e;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_ptr = 0; sb.delete();
            prev_rv = 2'b00; en_cnt = 0; clr_cnt = 0;
        end else begin
            g = (req_valid == 2'b11) ? m_ptr : req_valid[1];
            exp_rdy = (!m_busy && req_valid != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
            chk("req_ready", req_ready, exp_rdy);
            chk("busy", busy, m_busy);
            if (mac_en) en_cnt++;
            if (!mac_clr_n) clr_cnt++;
            if (rsp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("stray rsp_valid", rsp_valid, 2'b00);
                end else begin
                    e = sb[0];
                    chk("rsp_valid owner", rsp_valid, e.owner ? 2'b10 : 2'b01);
                    chk("rsp_data", rsp_data, e.data);
                    if (prev_rv == 2'b00) begin
                        chk("latency", cyc - e.t_acc, ITER + 2);
                        chk("mac_en cycles", en_cnt, ITER);
                        chk("clear cycles", clr_cnt, 1);
                    end else begin
                        chk("rsp_data stable", rsp_data, prev_data);
                    end
                    if (rsp_ready[e.owner]) begin
                        void'(sb.pop_front());
                        m_busy = 0;
                    end
                end
            end
            if ((req_valid & exp_rdy) != 2'b00) begin
                ea = g ? req_a[W +: W] : req_a[0 +: W];
                eb = g ? req_b[W +: W] : req_b[0 +: W];
                sb.push_back('{owner: g, data: {{W{1'b0}}, ea} * {{W{1'b0}}, eb}, t_acc: cyc + 1});
                m_busy = 1; m_ptr = ~g; en_cnt = 0; clr_cnt = 0;
            end
            prev_rv = rsp_valid;
            prev_data = rsp_data;
        end
    end

    bit stall0 = 0;
    initial begin
        logic [1:0] rr;
        forever begin
            @(posedge clk); #2;
            rr = 2'($urandom_range(0, 3));
            if (stall0) rr[0] = 1'b0;
            rsp_ready = rr;
        end
    end

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        bit ok;
        @(posedge clk); #2;
        if (id == 0) begin vld0 = 1'b1; a0 = a; b0 = b; end
        else         begin vld1 = 1'b1; a1 = a; b1 = b; end
        ok = 0;
        for (int n = 0; n < 3000 && !ok; n++) begin
            @(negedge clk);
            if (rst_n && req_ready[id]) ok = 1;
        end
        chk(name, ok, 1'b1);
        @(posedge clk); #2;
        if (id == 0) vld0 = 1'b0; else vld1 = 1'b0;
    endtask

    task automatic wait_rsp(input logic [1:0] exp_rv, input logic [2*W-1:0] exp_data, input string name);
        bit seen;
        seen = 0;
        for (int n = 0; n < 1000 && !seen; n++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) seen = 1;
        end
        chk({name, " seen"}, seen, 1'b1);
        chk({name, " owner"}, rsp_valid, exp_rv);
        chk({name, " data"}, rsp_data, exp_data);
        for (int n = 0; n < 200 && rsp_valid != 2'b00; n++) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy && rsp_valid == 2'b00) break;
        end
        chk(name, sb.size(), 0);
    endtask

    initial begin
        vld0 = 1'b1; a0 = W'(5);   b0 = W'(10);
        vld1 = 1'b1; a1 = W'(100); b1 = W'(100);
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", req_ready, 2'b00);
        chk("reset rsp_valid", rsp_valid, 2'b00);
        chk("reset mac_en", mac_en, 1'b0);
        chk("reset mac_clr_n", mac_clr_n, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset rsp_data", rsp_data, '0);

        // Both pending at reset exit: req0 first, then req1.
        fork
            issue(0, W'(5), W'(10), "accept rr req0");
            issue(1, W'(100), W'(100), "accept rr req1");
            begin @(posedge clk); #2; rst_n = 1'b1; end
            begin
                wait_rsp(2'b01, 50, "rr first");
                wait_rsp(2'b10, 10000, "rr second");
            end
        join
        wait_idle("drain rr");

        fork
            issue(0, W'(32), W'(32), "accept 32x32");
            wait_rsp(2'b01, 1024, "32x32");
        join
        wait_idle("drain 32x32");

        for (int k = 0; k < 3; k++) issue(1, rand_w(), rand_w(), "accept b2b req1");
        wait_idle("drain b2b");

        // Owner withholds accept while req1 waits behind it.
        stall0 = 1;
        fork
            issue(0, rand_w(), rand_w(), "accept stall req0");
            begin
                bit seen;
                seen = 0;
                for (int n = 0; n < ITER + 50 && !seen; n++) begin
                    @(negedge clk);
                    if (rsp_valid[0]) seen = 1;
                end
                chk("stall rsp seen", seen, 1'b1);
                repeat (20) begin
                    @(negedge clk);
                    chk("stall req_ready", req_ready, 2'b00);
                    chk("stall busy", busy, 1'b1);
                    chk("stall rsp_valid", rsp_valid, 2'b01);
                end
                stall0 = 0;
            end
            begin repeat (ITER + 8) @(posedge clk); issue(1, rand_w(), rand_w(), "accept after stall"); end
        join
        wait_idle("drain stall");

        // Reset while the counter is at 60.
        issue(0, rand_w(), rand_w(), "accept abort");
        repeat (61) @(posedge clk);
        #2;
        vld1 = 1'b1; a1 = rand_w(); b1 = rand_w();
        chk("abort in run", mac_en, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort req_ready", req_ready, 2'b00);
        chk("abort mac_en", mac_en, 1'b0);
        chk("abort mac_clr_n", mac_clr_n, 1'b0);
        chk("abort busy", busy, 1'b0);
        chk("abort rsp_data", rsp_data, '0);
        chk("abort mac_a", mac_a, '0);
        chk("abort mac_b", mac_b, '0);
        vld1 = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b1;
        #1;
        chk("release mac_clr_n", mac_clr_n, 1'b1);
        repeat (ITER + 20) @(negedge clk);
        chk("release busy", busy, 1'b0);

        fork
            for (int k = 0; k < 6; k++) begin
                repeat ($urandom_range(0, 20)) @(posedge clk);
                issue(0, rand_w(), rand_w(), "accept rand req0");
            end
            for (int k = 0; k < 6; k++) begin
                repeat ($urandom_range(0, 20)) @(posedge clk);
                issue(1, rand_w(), rand_w(), "accept rand req1");
            end
        join
        wait_idle("drain random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_sched.md
MAC_SCHED -- requirements
Module: mac_sched

Interface
REQ-001 SHALL have parameter W, default 256, operand width per MAC input.
REQ-002 SHALL have parameter ITER, default 128, MAC enable cycles per operation (radix-4 over W bits).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-006 SHALL have port req_ready  output  2  per-requester request accept.
REQ-007 SHALL have port req_a  input  2*W  operand A; requester i in bits [i*W +: W].
REQ-008 SHALL have port req_b  input  2*W  operand B; same packing as req_a.
REQ-009 SHALL have port rsp_valid  output  2  per-requester result valid.
REQ-010 SHALL have port rsp_ready  input  2  per-requester result accept.
REQ-011 SHALL have port rsp_data  output  2*W  result of the current response, shared by both requesters.
REQ-012 SHALL have port mac_a  output  W  operand A to the MAC.
REQ-013 SHALL have port mac_b  output  W  operand B to the MAC.
REQ-014 SHALL have port mac_en  output  1  MAC step enable.
REQ-015 SHALL have port mac_clr_n  output  1  MAC accumulator clear, active-low.
REQ-016 SHALL have port mac_out  input  2*W  MAC accumulator output.
REQ-017 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, CLEAR, RUN, CAPT, RESP; one transaction in flight at a time.
REQ-019 IDLE: SHALL drive req_ready high for exactly one requester (the grant) when any req_valid is high; all other states drive req_ready = 0.
REQ-020 Grant SHALL be round-robin: a 1-bit pointer names the preferred requester; if only one is valid it is granted regardless of the pointer.
REQ-021 On req_valid & req_ready SHALL register operands and owner ID, set the pointer to the non-owner, and go to CLEAR.
REQ-022 CLEAR: SHALL drive mac_clr_n = 0 and mac_en = 0 for exactly one cycle, clear the iteration counter, then go to RUN.
REQ-023 RUN: SHALL drive mac_en = 1 for exactly ITER consecutive cycles, counter 0..ITER-1, then go to CAPT.
REQ-024 CAPT: SHALL drive mac_en = 0 and register mac_out into the result register, then go to RESP.
REQ-025 RESP: SHALL assert rsp_valid[owner] only, hold rsp_data stable, and return to IDLE on rsp_ready[owner].
REQ-026 SHALL ignore rsp_ready of the non-owner.
REQ-027 mac_a and mac_b SHALL come from the operand registers and stay stable from CLEAR through CAPT.
REQ-028 Latency: rsp_valid SHALL rise exactly ITER+2 cycles after the acceptance edge.
REQ-029 A new request SHALL be accepted no earlier than the cycle after the response handshake, because IDLE is re-entered first.
REQ-030 The counter SHALL be clog2(ITER) bits wide and SHALL NOT wrap within a transaction.
REQ-031 mac_clr_n SHALL be 1 in all states except CLEAR, and SHALL be 0 while rst_n is low.
REQ-032 Deasserting req_valid while not granted SHALL have no effect; protocol violations on granted requests are not checked.

Reset
REQ-033 On rst_n low, SHALL immediately (asynchronously) force state IDLE, pointer 0, counter 0, rsp_valid 0, req_ready 0, mac_en 0, busy 0, and operand and result registers 0.
REQ-034 Reset mid-transaction SHALL abandon the operation; no response SHALL be issued for it after reset release.

Verification
REQ-035 Req0 A=32, B=32, ITER=128 -> mac_en high for 128 cycles, rsp_valid[0] rises 130 cycles after acceptance, rsp_data=1024.
REQ-036 Both valid at reset exit, req0 A=5 B=10 and req1 A=100 B=100 -> req0 granted first giving 50, then req1 giving 10000; pointer alternates.
REQ-037 Hold rsp_ready[0]=0 for 20 cycles in RESP -> rsp_valid and rsp_data stable, req_ready stays 0, busy=1.
REQ-038 Pulse rst_n low during RUN at counter 60 -> outputs at reset values at once; after release, IDLE with no stray rsp_valid.
REQ-039 Req1 only, three back-to-back requests -> each granted; mac_clr_n low one cycle before each RUN; no accumulation across operations.
REQ-040 Assert rsp_ready[1] while owner is 0 -> no effect on FSM.
